// File: rtl/int_mul_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | int_mul_iter: iterative XLEN x XLEN -> 2*XLEN multiplier, BPC bits/cycle  |
// | Optional macro INT_MUL_EARLY_OUT_EN: leave CALC once multiplier is zero.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module int_mul_iter #(
  parameter int XLEN = 64,
  parameter int BPC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [1:0]        mode,
  input  logic [XLEN-1:0]   inp1,
  input  logic [XLEN-1:0]   inp2,
  output logic              busy,
  output logic              valid,
  output logic [2*XLEN-1:0] int_mul_out
);

  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]   out_q, out_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;

  logic            w_op1_signed;
  logic            w_op2_signed;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic [PW-1:0]   w_pp;
  logic            w_calc_done;

  // mode 2'b11 falls through to unsigned x unsigned
  assign w_op1_signed = (mode == 2'b01) || (mode == 2'b10);
  assign w_op2_signed = (mode == 2'b01);

  // The most negative value negates to itself, which read unsigned is 2^(XLEN-1).
  assign w_mag1 = (w_op1_signed && inp1[XLEN-1]) ? -inp1 : inp1;
  assign w_mag2 = (w_op2_signed && inp2[XLEN-1]) ? -inp2 : inp2;

  always_comb begin
    w_pp = '0;
    for (int i = 0; i < BPC; i++) begin
      if (mplier_q[i]) begin
        w_pp = w_pp + (mcand_q << i);
      end
    end
  end

`ifdef INT_MUL_EARLY_OUT_EN
  assign w_calc_done = (cnt_q == '0) || (mplier_q == '0);
`else
  assign w_calc_done = (cnt_q == '0);
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    out_d    = out_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            state_d  = CALC;
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, w_mag1};
            mplier_d = w_mag2;
            cnt_d    = CW'(N);
            neg_d    = (w_op1_signed & inp1[XLEN-1]) ^ (w_op2_signed & inp2[XLEN-1]);
          end
        end
        CALC: begin
          if (w_calc_done) begin
            state_d = FIX;
          end else begin
            acc_d    = acc_q + w_pp;
            mcand_d  = mcand_q << BPC;
            mplier_d = mplier_q >> BPC;
            cnt_d    = cnt_q - CW'(1);
          end
        end
        FIX: begin
          out_d   = neg_q ? -acc_q : acc_q;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      out_q    <= out_d;
    end
  end

  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign valid       = (state_q == DONE);
  assign int_mul_out = out_q;

endmodule
`default_nettype wire

// File: doc/int_mul_iter.md
INT_MUL_ITER -- requirements
Module: int_mul_iter

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the operand width in bits.
REQ-002 The block SHALL have parameter BPC, default 4, giving multiplier bits retired per cycle; XLEN SHALL be an integer multiple of BPC.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-006 The block SHALL have port flush, input, 1 bit: abort any operation in progress.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 unsigned x unsigned, 01 signed x signed, 10 signed inp1 x unsigned inp2, 11 treated as 00.
REQ-008 The block SHALL have ports inp1 and inp2, input, XLEN bits each: the operands.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking a new result.
REQ-011 The block SHALL have port int_mul_out, output, 2*XLEN bits: full-width product.

Function
REQ-012 The FSM SHALL use states IDLE, CALC, FIX and DONE; let N = XLEN/BPC.
REQ-013 In IDLE or DONE, start=1 and flush=0 at a rising edge SHALL latch inp1, inp2 and mode, clear the accumulator, load the iteration counter with N and enter CALC.
REQ-014 Operands SHALL be converted to magnitudes per mode, and the result sign SHALL be recorded as the XOR of the signed operand MSBs.
REQ-015 Each CALC cycle SHALL add (multiplicand magnitude x low BPC multiplier bits) into the accumulator at the current bit offset, shift the multiplier right by BPC and decrement the counter.
REQ-016 CALC SHALL go to FIX when the counter reaches 0; FIX SHALL two's-complement negate the 2*XLEN result if the recorded sign is 1, then go to DONE.
REQ-017 On entering DONE, int_mul_out SHALL be updated and valid SHALL be 1 for exactly one cycle.
REQ-018 int_mul_out SHALL hold its value until the next DONE or reset.
REQ-019 DONE SHALL return to IDLE unless a start is accepted in that cycle.
REQ-020 busy SHALL be 1 in CALC and FIX, and 0 otherwise.
REQ-021 Fixed latency: valid SHALL be high in the cycle beginning N+2 rising edges after the edge that accepted start.
REQ-022 start while busy=1 SHALL be ignored, with no queuing.
REQ-023 flush=1 SHALL move the FSM to IDLE at the next edge, with no valid pulse and int_mul_out unchanged.
REQ-024 When flush and start are high in the same cycle, flush SHALL win and start SHALL be dropped.
REQ-025 All arithmetic SHALL be modulo 2^(2*XLEN); the most negative operand SHALL be handled correctly (its magnitude is 2^(XLEN-1), held unsigned).

Reset
REQ-026 rst=1 SHALL, asynchronously, force state IDLE, busy=0, valid=0, int_mul_out=0, and clear the counter and accumulator.
REQ-027 Reset during CALC or FIX SHALL abandon the operation, and no valid SHALL follow reset release.
REQ-028 The first start SHALL be accepted on the first rising edge with rst=0.

Configuration
REQ-029 Macro INT_MUL_EARLY_OUT_EN, when defined, SHALL make CALC go to FIX on the cycle after the remaining multiplier magnitude becomes 0, giving latency of ceil(significant multiplier bits/BPC)+2 cycles, minimum 2 for a zero multiplier.
REQ-030 When INT_MUL_EARLY_OUT_EN is not defined, latency SHALL always be N+2 per REQ-021.
REQ-031 Results SHALL be identical with and without INT_MUL_EARLY_OUT_EN.

Verification
REQ-032 With XLEN=64, BPC=4, mode 00, inp1=0xFFFF_FFFF_FFFF_FFFF and inp2=2, int_mul_out SHALL be 0x1_FFFF_FFFF_FFFF_FFFE, with valid 18 cycles after start.
REQ-033 With mode 01, inp1=-3 and inp2=7, int_mul_out SHALL be -21 sign-extended to 128 bits; with inp1=inp2=0x8000_0000_0000_0000 the result SHALL be 0x4000_..._0 (2^126).
REQ-034 With mode 10, inp1=-1 and inp2=0xFFFF_FFFF_FFFF_FFFF, int_mul_out SHALL be 0xFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001.
REQ-035 A second start pulsed at cycle 5 of an operation SHALL be ignored, and exactly one valid pulse SHALL occur.
REQ-036 flush at cycle 8 of CALC SHALL give busy=0 next cycle, no valid, and int_mul_out still holding the prior result; a start in the DONE cycle SHALL give a back-to-back valid 18 cycles later.
REQ-037 Raising rst mid-CALC SHALL give immediate busy=0 and int_mul_out=0; with INT_MUL_EARLY_OUT_EN, inp2=3 SHALL give valid 3 cycles after start.
